// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, legal oversampling ratios and parity types.
// Used by both the TX and RX paths.
package uart_pkg;

  localparam int unsigned EDGE_W   = 5;
  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Only the three oversampling ratios shared with the RX side are accepted
  function automatic logic presc_legal(input int unsigned presc);
    return (presc == PRESC_8) || (presc == PRESC_16) || (presc == PRESC_32);
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timing for the UART transmitter: per-bit clock counter with a latched prescale,
// terminal-count pulse and a saturating data-bit index.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6,
  parameter int unsigned BIT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PRESC_W-1:0] presc_in,
  input  logic               en,
  input  logic               bit_adv,
  output logic               tc_c,
  output logic [BIT_W-1:0]   bit_idx,
  output logic               last_bit_c
);

  logic [PRESC_W-1:0] presc_q;
  logic [EDGE_W-1:0]  edge_cnt;

  assign tc_c       = en && (PRESC_W'(edge_cnt) == PRESC_W'(presc_q - 1'b1));
  assign last_bit_c = (bit_idx == BIT_W'(DATA_WIDTH - 1));

  // Load restarts timing for a new frame; the bit index never wraps past the last data bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      edge_cnt <= '0;
      bit_idx  <= '0;
    end else if (load) begin
      presc_q  <= presc_in;
      edge_cnt <= '0;
      bit_idx  <= '0;
    end else if (en) begin
      if (tc_c) begin
        edge_cnt <= '0;
        if (bit_adv && !last_bit_c) begin
          bit_idx <= BIT_W'(bit_idx + 1'b1);
        end
      end else begin
        edge_cnt <= EDGE_W'(edge_cnt + 1'b1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: latches one byte per accepted request and shifts out
// start, LSB-first data, optional parity and stop bits, each held Prescale clocks.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  parity_q;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  load_c;
  logic                  presc_ok_c;
  logic                  tc_c;
  logic                  last_bit_c;
  logic [BIT_W-1:0]      bit_idx;
  logic [BIT_W-1:0]      next_idx_c;

  assign presc_ok_c = presc_legal(32'(Prescale));
  assign next_idx_c = BIT_W'(bit_idx + 1'b1);

  uart_tx_bit_timer #(
    .DATA_WIDTH (DATA_WIDTH),
    .PRESC_W    (PRESC_W),
    .BIT_W      (BIT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (load_c),
    .presc_in   (Prescale),
    .en         (state_q != IDLE),
    .bit_adv    (state_q == DATA),
    .tc_c       (tc_c),
    .bit_idx    (bit_idx),
    .last_bit_c (last_bit_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Frame payload is frozen at acceptance so input changes mid-frame are harmless
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
    end else if (load_c) begin
      data_q   <= P_DATA;
      par_en_q <= PAR_EN;
      parity_q <= (^P_DATA) ^ PAR_TYP;
    end
  end

  // Next state plus the line value of the bit about to be presented
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (Data_Valid && presc_ok_c) begin
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          load_c  = 1'b1;
        end
      end
      START: begin
        if (tc_c) begin
          state_d = DATA;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (tc_c) begin
          if (!last_bit_c) begin
            tx_d = data_q[next_idx_c];
          end else if (par_en_q) begin
            state_d = PARITY;
            tx_d    = parity_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end
      end
      PARITY: begin
        if (tc_c) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (tc_c) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: stimulus queues expected line sequences,
// a monitor checks each frame bit-by-bit as Busy rises.
module tb_uart_tx_frame;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic       tx_out;
  logic       busy;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (p_data),
    .Data_Valid (data_valid),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .Prescale   (prescale),
    .TX_OUT     (tx_out),
    .Busy       (busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int frame_no = 0;
  int idle_run = 0;

  string exp_seq[$];
  int    exp_presc[$];
  bit    exp_gap1[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  task automatic push(string seq, int presc, bit gap1);
    exp_seq.push_back(seq);
    exp_presc.push_back(presc);
    exp_gap1.push_back(gap1);
  endtask

  // Called on the first negedge with Busy high; returns on the idle sample after the frame
  task automatic run_frame();
    string seq;
    int    presc;
    bit    gap1;
    int    good;
    logic  ebit;
    frame_no++;
    if (exp_seq.size() == 0) begin
      chk($sformatf("f%0d_unexpected_frame", frame_no), 1, 0);
      for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
      idle_run = 0;
      return;
    end
    seq   = exp_seq.pop_front();
    presc = exp_presc.pop_front();
    gap1  = exp_gap1.pop_front();
    if (gap1) chk($sformatf("f%0d_gap", frame_no), idle_run, 1);
    for (int b = 0; b < seq.len(); b++) begin
      good = 0;
      ebit = (seq[b] == "1");
      for (int k = 0; k < presc; k++) begin
        if (k > 0 || b > 0) @(negedge clk);
        if (rst) begin
          idle_run = 0;
          return;
        end
        if (busy === 1'b1 && tx_out === ebit) good++;
      end
      chk($sformatf("f%0d_bit%0d_hold", frame_no, b), good, presc);
    end
    @(negedge clk);
    if (rst) begin
      idle_run = 0;
      return;
    end
    chk($sformatf("f%0d_end_busy_tx", frame_no), {30'd0, busy, tx_out}, 32'd1);
    idle_run = 1;
  endtask

  initial begin : monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        idle_run = 0;
      end else if (busy === 1'b1 && !prev) begin
        run_frame();
        prev = busy;
      end else begin
        if (busy === 1'b0) idle_run++;
        prev = busy;
      end
    end
  end

  task automatic send(logic [7:0] d, logic pe, logic pt, logic [5:0] ps);
    p_data = d;
    par_en = pe;
    par_typ = pt;
    prescale = ps;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, busy, 1'b0);
  endtask

  initial begin : stimulus
    int ok;
    int n;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx_out, 1'b1);
    chk("reset_busy", busy, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    push("0101001011", 8, 1'b0);
    send(8'hA5, 1'b0, PAR_EVEN, 6'd8);
    wait_idle("a5");
    repeat (3) @(negedge clk);

    push("01110000011", 16, 1'b0);
    send(8'h07, 1'b1, PAR_EVEN, 6'd16);
    wait_idle("07_even");
    repeat (3) @(negedge clk);

    push("01110000001", 16, 1'b0);
    send(8'h07, 1'b1, PAR_ODD, 6'd16);
    wait_idle("07_odd");
    repeat (3) @(negedge clk);

    // Back-to-back with Data_Valid held and P_DATA changed mid-frame
    push("0101010101", 32, 1'b0);
    push("0111111111", 32, 1'b1);
    p_data = 8'h55;
    par_en = 1'b0;
    prescale = 6'd32;
    data_valid = 1'b1;
    @(negedge clk);
    p_data = 8'hFF;
    wait_idle("b2b_first");
    n = 0;
    while (busy !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second_start", busy, 1'b1);
    data_valid = 1'b0;
    wait_idle("b2b_second");
    repeat (3) @(negedge clk);

    // Request while busy is dropped
    push("0110000111", 8, 1'b0);
    send(8'hC3, 1'b0, PAR_EVEN, 6'd8);
    repeat (20) @(negedge clk);
    p_data = 8'h00;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_idle("c3");
    repeat (10) @(negedge clk);

    // Illegal prescale holds off the request until a legal one appears
    push("01000000111", 8, 1'b0);
    p_data = 8'h81;
    par_en = 1'b1;
    par_typ = PAR_ODD;
    prescale = 6'd12;
    data_valid = 1'b1;
    ok = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_out === 1'b1 && busy === 1'b0) ok++;
    end
    chk("presc12_idle", ok, 20);
    prescale = 6'd8;
    @(negedge clk);
    chk("presc8_start", {30'd0, busy, tx_out}, 32'd2);
    data_valid = 1'b0;
    wait_idle("81");
    repeat (3) @(negedge clk);

    // Reset during data bit 3 abandons the frame
    push("0000011111", 8, 1'b0);
    send(8'hF0, 1'b0, PAR_EVEN, 6'd8);
    repeat (34) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_tx", tx_out, 1'b1);
    chk("rst_async_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {30'd0, busy, tx_out}, 32'd1);

    push("0001111001", 8, 1'b0);
    send(8'h3C, 1'b0, PAR_EVEN, 6'd8);
    wait_idle("3c");
    repeat (5) @(negedge clk);

    chk("queue_empty", exp_seq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter: accepts one parallel byte per handshake and serializes it onto TX_OUT.
- Frame format: start bit, LSB-first data, optional parity, one stop bit.
- Each bit is held for Prescale system clocks, so the TX and RX ends share the oversampling ratio (8/16/32) from one configuration source.
- Sits between the UART register/FIFO front end and the serial pin, opposite the RX edge/bit counting path.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESC_W, 6, width of the Prescale input.

Ports:
- clk, input, 1, system clock (single clock domain).
- rst, input, 1, asynchronous active-high reset.
- P_DATA, input, DATA_WIDTH, parallel byte to send.
- Data_Valid, input, 1, request to send P_DATA (single-cycle pulse or level).
- PAR_EN, input, 1, 1 = insert parity bit.
- PAR_TYP, input, 1, 0 = even parity, 1 = odd parity.
- Prescale, input, PRESC_W, clocks per bit; legal values 8, 16, 32.
- TX_OUT, output, 1, serial line; idle high.
- Busy, output, 1, high while a frame is in progress.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. All outputs are registered.
- Reset (async, any time including mid-frame):
  - state=IDLE, TX_OUT=1, Busy=0.
  - Bit and edge counters=0; data and parity registers=0.
  - A frame interrupted by reset is abandoned, not resumed.
- State machine IDLE -> START -> DATA -> PARITY -> STOP -> IDLE. PARITY is skipped when the latched PAR_EN=0.
- Acceptance rule:
  - Data_Valid is sampled only in IDLE.
  - At edge N with Data_Valid=1 and a legal Prescale, the block latches P_DATA, PAR_EN, PAR_TYP and Prescale, and computes parity = (^P_DATA) XOR PAR_TYP.
  - At edge N the block enters START; TX_OUT=0 and Busy=1 are visible after edge N.
- Input stability: changes to P_DATA/PAR_*/Prescale during a frame do not affect that frame.
- Illegal Prescale (anything other than 8/16/32) in IDLE: the request is ignored; the block stays IDLE with TX_OUT=1 and Busy=0.
- Bit timing: edge counter runs 0..Prescale-1 in every non-IDLE state. On the terminal count, the edge counter wraps to 0 and the FSM advances or the bit counter increments.
- Per-state line value:
  - START: drives 0.
  - DATA: drives data[bit_count], bit_count 0..DATA_WIDTH-1; leaves on the terminal count of bit DATA_WIDTH-1.
  - PARITY: drives the latched parity.
  - STOP: drives 1.
- Frame end: on the terminal count of STOP, the FSM returns to IDLE and Busy drops at that edge.
- Frame length: (DATA_WIDTH+2+PAR_EN)*Prescale clocks. Example: 8 data bits, parity on, Prescale=16 → 176 clocks of Busy=1.
- Back-to-back frames:
  - Data_Valid held high through STOP is sampled in IDLE on the cycle after Busy falls.
  - A new START therefore begins 1 clock after STOP ends. The 1-clock idle-high gap is required.
- Data_Valid while Busy=1 is ignored (no queuing). The upstream block must wait for Busy=0.
- Counter widths: edge counter 5 bits (max 31); bit counter sized to DATA_WIDTH, no wrap beyond DATA_WIDTH-1.
- No X on TX_OUT in any state; the default FSM branch forces IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - legal prescale constants PRESC_8/16/32;
  - parity type constants PAR_EVEN=0, PAR_ODD=1.
- The package is shared with the RX side.
- One sub-module, uart_tx_bit_timer: edge/bit counter with enable, latched prescale, terminal-count pulse, and bit index output.
- The top module holds the FSM, data and parity registers, and the output mux.

Test Plan:
- Reset mid-frame: assert rst during DATA bit 3 → TX_OUT=1 and Busy=0 immediately (asynchronously). After release, Data_Valid with P_DATA=0x3C sends a clean full frame.
- P_DATA=0xA5, PAR_EN=0, Prescale=8, one-cycle Data_Valid → line reads 0,1,0,1,0,0,1,0,1,1, each bit held exactly 8 clocks; Busy high for 80 clocks.
- P_DATA=0x07, PAR_EN=1, PAR_TYP=0, Prescale=16 → parity bit=1; Busy high for 176 clocks. Repeat with PAR_TYP=1 → parity bit=0.
- Back-to-back: Data_Valid held high with 0x55 then 0xFF, Prescale=32 → two frames separated by exactly 1 idle-high clock. P_DATA change mid-frame does not corrupt the first frame.
- Prescale=12 with Data_Valid=1 → no frame sent; TX_OUT stays 1 and Busy stays 0. Switch to Prescale=8 → frame starts on the next clock.
- Data_Valid pulse while Busy=1 (P_DATA=0x00) → ignored; only the original frame appears on the line.
